// File: rtl/jtframe_bank_client.sv
// rtl/jtframe_bank_client.sv - game-side SDRAM bank requester with a 1-line, 2-word read cache
`timescale 1ns/1ps

module jtframe_bank_client #(
  parameter int                SDRAMW = 22,
  parameter int                AW     = 18,
  parameter int                DW     = 8,
  parameter logic [SDRAMW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  output logic [DW-1:0]     dout,
  output logic              data_ok,
  output logic [SDRAMW-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic              sdram_ack,
  input  logic              sdram_dst,
  input  logic              sdram_dok,
  input  logic              sdram_rdy,
  input  logic [15:0]       data_read
);

  // Word-index width and line-tag width (a line holds two 16-bit words)
  localparam int WW = (DW == 8) ? AW - 1 : AW;
  localparam int TW = WW - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tag_q, tag_d;
  logic                valid_q, valid_d;
  logic [15:0]         word0_q, word0_d;
  logic [15:0]         word1_q, word1_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                data_ok_q, data_ok_d;
  logic                sdram_rd_q, sdram_rd_d;
  logic [SDRAMW-1:0]   sdram_addr_q, sdram_addr_d;

  logic [WW-1:0]       w;
  logic [TW-1:0]       cur_tag;
  logic [SDRAMW-1:0]   line_addr;
  logic [15:0]         word_sel;
  logic [DW-1:0]       sel_data;
  logic                hit;

  // Byte-addressed games drop the byte bit to get the word index; byte lane picked by addr[0]
  generate
    if (DW == 8) begin : g_byte
      assign w        = addr[AW-1:1];
      assign sel_data = addr[0] ? word_sel[15:8] : word_sel[7:0];
    end else begin : g_word
      assign w        = addr;
      assign sel_data = word_sel;
    end
  endgenerate

  assign cur_tag   = w[WW-1:1];
  assign line_addr = OFFSET + SDRAMW'({cur_tag, 1'b0});
  assign word_sel  = w[0] ? word1_q : word0_q;
  assign hit       = valid_q && (cur_tag == tag_q) && addr_ok;

  assign dout       = dout_q;
  assign data_ok    = data_ok_q;
  assign sdram_rd   = sdram_rd_q;
  assign sdram_addr = sdram_addr_q;

  // Next-state: registered hit output plus the request/fill FSM
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    word0_d      = word0_q;
    word1_d      = word1_q;
    sdram_rd_d   = sdram_rd_q;
    sdram_addr_d = sdram_addr_q;
    dout_d       = hit ? sel_data : dout_q;
    data_ok_d    = hit;

    case (state_q)
      ST_IDLE: begin
        // Only one request in flight; the cache is invalidated while it refills
        if (addr_ok && !hit) begin
          state_d      = ST_REQ;
          tag_d        = cur_tag;
          sdram_addr_d = line_addr;
          sdram_rd_d   = 1'b1;
          valid_d      = 1'b0;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          sdram_rd_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dst && sdram_dok) begin
          word0_d = data_read;
        end
        // The burst always fills the latched tag, even if addr moved meanwhile
        if (sdram_rdy) begin
          word1_d = data_read;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      word0_q      <= '0;
      word1_q      <= '0;
      dout_q       <= '0;
      data_ok_q    <= 1'b0;
      sdram_rd_q   <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      word0_q      <= word0_d;
      word1_q      <= word1_d;
      dout_q       <= dout_d;
      data_ok_q    <= data_ok_d;
      sdram_rd_q   <= sdram_rd_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

endmodule
